// File: rtl/muller_c_pkg.sv
// Shared types and constants for the Muller C-element handshake driver.
// FSM state encoding, error codes and default timing parameters.
package muller_c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_A_UP      = 3'd1,
      ST_B_UP_WAIT = 3'd2,
      ST_A_DN      = 3'd3,
      ST_B_DN_WAIT = 3'd4,
      ST_DONE      = 3'd5,
      ST_ERR       = 3'd6
   } state_e;

   localparam logic [1:0] ERR_NONE      = 2'b00;
   localparam logic [1:0] ERR_PREMATURE = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT   = 2'b10;
   localparam logic [1:0] ERR_GLITCH    = 2'b11;

   localparam int DEF_SKEW_CYC    = 2;
   localparam int DEF_TIMEOUT_CYC = 64;

endpackage

// File: rtl/muller_c_sync2.sv
// Two-flop synchronizer for a single asynchronous bit; 2-cycle latency, no flow control.
// Synchronous active-high reset clears both stages.
module muller_c_sync2 (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic r_s1;
   logic r_s2;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= i_d;
         r_s2 <= r_s1;
      end
   end

   assign o_q = r_s2;

endmodule

// File: rtl/muller_c_driver.sv
// Drives a C-element through n skewed 4-phase handshakes and checks its output via c_s.
// a_o/b_o are registered from the next state; start_i is only honoured in IDLE or ERR.
module muller_c_driver
   import muller_c_pkg::*;
#(
   parameter int SKEW_CYC    = DEF_SKEW_CYC,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic       start_i,
   input  logic [7:0] n_hs_i,
   input  logic       c_i,
   output logic       a_o,
   output logic       b_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       err_o,
   output logic [1:0] err_code_o,
   output logic [7:0] hs_count_o
);

   localparam logic [3:0] SKEW_LOAD = 4'(SKEW_CYC - 1);
   localparam logic [7:0] TO_LAST   = 8'(TIMEOUT_CYC - 1);

   logic       w_c_s;
   state_e     r_state;
   state_e     w_nxt;
   logic [3:0] r_skew;
   logic [7:0] r_to;
   logic [7:0] r_n_hs;
   logic [7:0] r_hs;
   logic [7:0] w_hs_plus;
   logic       r_a, r_b, r_busy, r_done, r_err;
   logic [1:0] r_err_code;
   logic       w_accept, w_set_err, w_hs_inc;
   logic [1:0] w_code;

   muller_c_sync2 u_sync (
      .i_clk (wb_clk_i),
      .i_rst (wb_rst_i),
      .i_d   (c_i),
      .o_q   (w_c_s)
   );

   assign w_hs_plus = r_hs + 8'd1;

   always_comb begin
      w_nxt     = r_state;
      w_accept  = 1'b0;
      w_set_err = 1'b0;
      w_code    = ERR_NONE;
      w_hs_inc  = 1'b0;
      case (r_state)
         ST_IDLE, ST_ERR: begin
            if (start_i) begin
               w_accept = 1'b1;
               w_nxt    = (n_hs_i == 8'd0) ? ST_DONE : ST_A_UP;
            end
         end
         ST_A_UP: begin
            if (w_c_s) begin
               w_nxt     = ST_ERR;
               w_set_err = 1'b1;
               w_code    = ERR_PREMATURE;
            end else if (r_skew == 4'd0) begin
               w_nxt = ST_B_UP_WAIT;
            end
         end
         ST_B_UP_WAIT: begin
            if (w_c_s) begin
               w_nxt = ST_A_DN;
            end else if (r_to == TO_LAST) begin
               w_nxt     = ST_ERR;
               w_set_err = 1'b1;
               w_code    = ERR_TIMEOUT;
            end
         end
         ST_A_DN: begin
            if (!w_c_s) begin
               w_nxt     = ST_ERR;
               w_set_err = 1'b1;
               w_code    = ERR_GLITCH;
            end else if (r_skew == 4'd0) begin
               w_nxt = ST_B_DN_WAIT;
            end
         end
         ST_B_DN_WAIT: begin
            if (!w_c_s) begin
               w_hs_inc = 1'b1;
               w_nxt    = (w_hs_plus == r_n_hs) ? ST_DONE : ST_A_UP;
            end else if (r_to == TO_LAST) begin
               w_nxt     = ST_ERR;
               w_set_err = 1'b1;
               w_code    = ERR_TIMEOUT;
            end
         end
         ST_DONE: w_nxt = ST_IDLE;
         default: w_nxt = ST_IDLE;
      endcase
   end

   // Outputs decode the next state so they line up with r_state and stay glitch-free.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state    <= ST_IDLE;
         r_skew     <= 4'd0;
         r_to       <= 8'd0;
         r_n_hs     <= 8'd0;
         r_hs       <= 8'd0;
         r_a        <= 1'b0;
         r_b        <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= ERR_NONE;
      end else begin
         r_state <= w_nxt;
         r_a     <= (w_nxt == ST_A_UP) || (w_nxt == ST_B_UP_WAIT);
         r_b     <= (w_nxt == ST_B_UP_WAIT) || (w_nxt == ST_A_DN);
         r_busy  <= (w_nxt == ST_A_UP) || (w_nxt == ST_B_UP_WAIT) ||
                    (w_nxt == ST_A_DN) || (w_nxt == ST_B_DN_WAIT);
         r_done  <= (w_nxt == ST_DONE);

         if (w_nxt != r_state) begin
            r_skew <= SKEW_LOAD;
            r_to   <= 8'd0;
         end else begin
            if (r_skew != 4'd0) r_skew <= r_skew - 4'd1;
            if (r_to != TO_LAST) r_to <= r_to + 8'd1;
         end

         if (w_accept) begin
            r_n_hs     <= n_hs_i;
            r_hs       <= 8'd0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
         end else if (w_hs_inc) begin
            r_hs <= w_hs_plus;
         end

         if (w_set_err) begin
            r_err      <= 1'b1;
            r_err_code <= w_code;
         end
      end
   end

   assign a_o        = r_a;
   assign b_o        = r_b;
   assign busy_o     = r_busy;
   assign done_o     = r_done;
   assign err_o      = r_err;
   assign err_code_o = r_err_code;
   assign hs_count_o = r_hs;

endmodule

// File: tb/tb_muller_c_driver.sv
// Scoreboarded bench for muller_c_driver against ideal, stuck-low and OR-gate C-element models.
module tb_muller_c_driver;
   import muller_c_pkg::*;

   localparam int SKEW = 4;
   localparam int TMO  = 16;
   localparam int M_IDEAL = 0, M_STUCK0 = 1, M_OR = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] n_hs = 8'd0;
   logic       c = 1'b0;
   logic       a, b, busy, done, err;
   logic [1:0] code;
   logic [7:0] hs;
   int         mode = M_IDEAL;

   typedef struct {
      logic       done;
      logic       err;
      logic [1:0] code;
      logic [7:0] hs;
   } exp_t;
   exp_t sb[$];

   int n_err = 0;
   int n_chk = 0;
   int done_cnt, a_rise, ab_any, ab_both;
   logic a_q = 1'b0;

   muller_c_driver #(.SKEW_CYC(SKEW), .TIMEOUT_CYC(TMO)) dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .start_i    (start),
      .n_hs_i     (n_hs),
      .c_i        (c),
      .a_o        (a),
      .b_o        (b),
      .busy_o     (busy),
      .done_o     (done),
      .err_o      (err),
      .err_code_o (code),
      .hs_count_o (hs)
   );

   always #5 clk = ~clk;

   always @(a or b or mode) begin
      case (mode)
         M_IDEAL: begin
            if (a && b) c = 1'b1;
            else if (!a && !b) c = 1'b0;
         end
         M_STUCK0: c = 1'b0;
         default:  c = a | b;
      endcase
   end

   always @(posedge clk) begin
      #1;
      if (done) done_cnt++;
      if (a && !a_q) a_rise++;
      if (a || b) ab_any++;
      if (a && b) ab_both++;
      a_q = a;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic clear_mon();
      done_cnt = 0; a_rise = 0; ab_any = 0; ab_both = 0;
   endtask

   task automatic pulse_start(input logic [7:0] n);
      @(negedge clk);
      start = 1'b1;
      n_hs  = n;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic push_exp(input logic d, input logic e, input logic [1:0] cd, input logic [7:0] h);
      exp_t x;
      x.done = d; x.err = e; x.code = cd; x.hs = h;
      sb.push_back(x);
   endtask

   task automatic wait_and_score(input string tag);
      int   cyc = 0;
      exp_t x;
      while (!(done || err) && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      check_val({tag, "_no_timeout"}, (cyc < 2000), 1);
      if (sb.size() == 0) begin
         check_val({tag, "_sb_empty"}, 0, 1);
      end else begin
         x = sb.pop_front();
         check_val({tag, "_done"}, done, x.done);
         check_val({tag, "_err"},  err,  x.err);
         check_val({tag, "_code"}, code, x.code);
         check_val({tag, "_hs"},   hs,   x.hs);
      end
   endtask

   initial begin
      int cyc;
      clear_mon();
      // Reset with a simultaneous start request that must be ignored.
      repeat (2) @(negedge clk);
      start = 1'b1; n_hs = 8'd2;
      @(negedge clk);
      start = 1'b0;
      check_val("rst_a", a, 0);
      check_val("rst_b", b, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_err", err, 0);
      check_val("rst_code", code, 0);
      check_val("rst_hs", hs, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_val("rst_start_ignored", busy, 0);

      // Ideal C-element, three handshakes, stray start while busy.
      clear_mon();
      push_exp(1'b1, 1'b0, ERR_NONE, 8'd3);
      pulse_start(8'd3);
      repeat (5) @(negedge clk);
      check_val("ideal_busy", busy, 1);
      start = 1'b1; n_hs = 8'd7;
      @(negedge clk);
      start = 1'b0;
      wait_and_score("ideal3");
      repeat (3) @(negedge clk);
      check_val("ideal3_done_pulses", done_cnt, 1);
      check_val("ideal3_a_rises", a_rise, 3);
      check_val("ideal3_busy_after", busy, 0);

      // Zero handshakes: done the cycle after start, no drive.
      clear_mon();
      push_exp(1'b1, 1'b0, ERR_NONE, 8'd0);
      pulse_start(8'd0);
      check_val("n0_done_next", done, 1);
      wait_and_score("n0");
      repeat (3) @(negedge clk);
      check_val("n0_ab_never", ab_any, 0);
      check_val("n0_done_pulses", done_cnt, 1);

      // Output stuck low: timeout in B_UP_WAIT after exactly TMO cycles.
      mode = M_STUCK0;
      clear_mon();
      push_exp(1'b0, 1'b1, ERR_TIMEOUT, 8'd0);
      pulse_start(8'd2);
      wait_and_score("stuck");
      check_val("stuck_a", a, 0);
      check_val("stuck_b", b, 0);
      check_val("stuck_busy", busy, 0);
      check_val("stuck_wait_cycles", ab_both, TMO);
      repeat (5) @(negedge clk);
      check_val("stuck_err_sticky", err, 1);

      // OR-gate model: output rises during A_UP.
      mode = M_OR;
      clear_mon();
      push_exp(1'b0, 1'b1, ERR_PREMATURE, 8'd0);
      pulse_start(8'd2);
      wait_and_score("orgate");
      check_val("orgate_no_bup", ab_both, 0);
      check_val("orgate_a", a, 0);

      // Start from ERR clears the error and runs normally.
      mode = M_IDEAL;
      clear_mon();
      push_exp(1'b1, 1'b0, ERR_NONE, 8'd1);
      pulse_start(8'd1);
      check_val("recover_err_cleared", err, 0);
      wait_and_score("recover");

      // Reset while in B_DN_WAIT of the second handshake.
      clear_mon();
      pulse_start(8'd3);
      cyc = 0;
      while (hs != 8'd1 && cyc < 500) begin @(negedge clk); cyc++; end
      while (b != 1'b1 && cyc < 500) begin @(negedge clk); cyc++; end
      while (b != 1'b0 && cyc < 500) begin @(negedge clk); cyc++; end
      check_val("midrst_reached", (cyc < 500), 1);
      check_val("midrst_hs_before", hs, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_val("midrst_a", a, 0);
      check_val("midrst_b", b, 0);
      check_val("midrst_busy", busy, 0);
      check_val("midrst_done", done, 0);
      check_val("midrst_err", err, 0);
      check_val("midrst_hs", hs, 0);
      repeat (4) @(negedge clk);
      push_exp(1'b1, 1'b0, ERR_NONE, 8'd1);
      pulse_start(8'd1);
      wait_and_score("post_rst");

      check_val("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
